// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle control FSM for a MIPS-subset datapath that shares one memory
//   and one ALU across cycles. Sequences each instruction through fetch,
//   decode, execute, memory and write-back, and drives every datapath enable
//   and mux select from the current state.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   opcode, funct   instruction fields (opcode valid from DECODE onward)
//   zero            ALU zero flag, used to resolve BEQ/BNE in BRANCH
//   mem_ready       memory completes the current access this cycle
//   PCWrite .. PCSource  datapath enables and mux selects
//   state           current state encoding (debug)
//   instr_done      one-cycle pulse on the last cycle of each instruction
//   illegal         one-cycle pulse when an unsupported instruction is decoded
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEXEC = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ITEXEC = 4'd10;
  localparam logic [3:0] S_ITWB   = 4'd11;
  localparam logic [3:0] S_JR     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [5:0] op_q;

  assign state = state_q;

  // State register and opcode latch. The opcode is captured in DECODE so
  // later states are immune to IR/opcode changes after the fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 6'h00;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  // Next-state logic. DECODE dispatches on the live opcode; later states use
  // the latched copy. Unused codes 13-15 fall through to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                        state_d = (funct == FN_JR) ? S_JR : S_RTEXEC;
          OP_LW, OP_SW, OP_SH, OP_SB:      state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
          OP_J:                            state_d = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_LUI:                  state_d = S_ITEXEC;
          default:                         state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXEC: state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ITEXEC: state_d = S_ITWB;
      S_ITWB:   state_d = S_FETCH;
      S_JR:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode. Everything defaults to 0; reset overrides all outputs so
  // no memory request or architectural write happens while rst is high.
  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSource   = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC and IR update only on the completing cycle of the fetch.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_SH, OP_SB, OP_BEQ, OP_BNE, OP_J,
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
        instr_done = illegal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RTWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSource   = 2'b01;
        PCWrite    = (op_q == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      S_ITEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      S_ITWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JR: begin
        PCSource   = 2'b11;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      PCSource   = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Inputs change 1 time unit
// after each rising edge; outputs are checked 2 units after the edge.
module tb_multicycle_controller;
  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic       RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal;

  int compared   = 0;
  int mismatched = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
    .instr_done(instr_done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    settle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_pcwrite", 32'(PCWrite), 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd0);

    // R-type add: 0,1,6,7,0
    rst = 1'b0; opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    settle();
    chk("rt_fetch_state", 32'(state), 32'd0);
    chk("rt_fetch_memread", 32'(MemRead), 32'd1);
    chk("rt_fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("rt_fetch_alusrcb", 32'(ALUSrcB), 32'd1);
    tick(); settle();
    chk("rt_decode_state", 32'(state), 32'd1);
    chk("rt_decode_alusrcb", 32'(ALUSrcB), 32'd3);
    chk("rt_decode_regwrite", 32'(RegWrite), 32'd0);
    tick(); settle();
    chk("rt_exec_state", 32'(state), 32'd6);
    chk("rt_exec_aluop", 32'(ALUOp), 32'd2);
    chk("rt_exec_alusrca", 32'(ALUSrcA), 32'd1);
    chk("rt_exec_regwrite", 32'(RegWrite), 32'd0);
    tick(); settle();
    chk("rt_wb_state", 32'(state), 32'd7);
    chk("rt_wb_regwrite", 32'(RegWrite), 32'd1);
    chk("rt_wb_regdst", 32'(RegDst), 32'd1);
    chk("rt_wb_done", 32'(instr_done), 32'd1);
    tick(); settle();
    chk("rt_back_state", 32'(state), 32'd0);
    chk("rt_back_done", 32'(instr_done), 32'd0);

    // LW with 2 fetch waits and 3 MEMRD waits: 10 cycles total
    opcode = 6'h23; mem_ready = 1'b0;
    settle();
    chk("lw_fw1_memread", 32'(MemRead), 32'd1);
    chk("lw_fw1_irwrite", 32'(IRWrite), 32'd0);
    chk("lw_fw1_pcwrite", 32'(PCWrite), 32'd0);
    tick(); settle();
    chk("lw_fw2_state", 32'(state), 32'd0);
    chk("lw_fw2_memread", 32'(MemRead), 32'd1);
    tick(); mem_ready = 1'b1; settle();
    chk("lw_f3_state", 32'(state), 32'd0);
    chk("lw_f3_irwrite", 32'(IRWrite), 32'd1);
    chk("lw_f3_pcwrite", 32'(PCWrite), 32'd1);
    tick(); settle();
    chk("lw_decode_state", 32'(state), 32'd1);
    // opcode changes after DECODE must not affect the latched dispatch
    tick(); opcode = 6'h2B; mem_ready = 1'b0; settle();
    chk("lw_memadr_state", 32'(state), 32'd2);
    chk("lw_memadr_alusrcb", 32'(ALUSrcB), 32'd2);
    chk("lw_memadr_alusrca", 32'(ALUSrcA), 32'd1);
    tick(); settle();
    chk("lw_rd1_state", 32'(state), 32'd3);
    chk("lw_rd1_iord", 32'(IorD), 32'd1);
    chk("lw_rd1_memread", 32'(MemRead), 32'd1);
    tick(); settle();
    chk("lw_rd2_state", 32'(state), 32'd3);
    chk("lw_rd2_iord", 32'(IorD), 32'd1);
    tick(); settle();
    chk("lw_rd3_state", 32'(state), 32'd3);
    chk("lw_rd3_memread", 32'(MemRead), 32'd1);
    tick(); mem_ready = 1'b1; settle();
    chk("lw_rd4_state", 32'(state), 32'd3);
    chk("lw_rd4_iord", 32'(IorD), 32'd1);
    chk("lw_rd4_regwrite", 32'(RegWrite), 32'd0);
    tick(); settle();
    chk("lw_wb_state", 32'(state), 32'd4);
    chk("lw_wb_regwrite", 32'(RegWrite), 32'd1);
    chk("lw_wb_memtoreg", 32'(MemtoReg), 32'd1);
    chk("lw_wb_regdst", 32'(RegDst), 32'd0);
    chk("lw_wb_done", 32'(instr_done), 32'd1);
    tick(); settle();
    chk("lw_back_state", 32'(state), 32'd0);

    // BEQ, zero=1: branch taken
    opcode = 6'h04; zero = 1'b1;
    tick(); tick(); settle();
    chk("beq_state", 32'(state), 32'd8);
    chk("beq_pcwrite", 32'(PCWrite), 32'd1);
    chk("beq_pcsource", 32'(PCSource), 32'd1);
    chk("beq_aluop", 32'(ALUOp), 32'd1);
    chk("beq_done", 32'(instr_done), 32'd1);
    tick(); settle();
    chk("beq_back_state", 32'(state), 32'd0);

    // BNE: zero=1 not taken, zero=0 taken
    opcode = 6'h05; zero = 1'b1;
    tick(); tick(); settle();
    chk("bne_state", 32'(state), 32'd8);
    chk("bne_z1_pcwrite", 32'(PCWrite), 32'd0);
    zero = 1'b0; settle();
    chk("bne_z0_pcwrite", 32'(PCWrite), 32'd1);
    tick(); settle();
    chk("bne_back_state", 32'(state), 32'd0);

    // JR: 0,1,12
    opcode = 6'h00; funct = 6'h08;
    tick(); tick(); settle();
    chk("jr_state", 32'(state), 32'd12);
    chk("jr_pcsource", 32'(PCSource), 32'd3);
    chk("jr_pcwrite", 32'(PCWrite), 32'd1);
    chk("jr_regwrite", 32'(RegWrite), 32'd0);
    chk("jr_done", 32'(instr_done), 32'd1);
    tick(); settle();
    chk("jr_back_state", 32'(state), 32'd0);

    // J: 0,1,9
    opcode = 6'h02; funct = 6'h00;
    tick(); tick(); settle();
    chk("j_state", 32'(state), 32'd9);
    chk("j_pcsource", 32'(PCSource), 32'd2);
    chk("j_pcwrite", 32'(PCWrite), 32'd1);
    tick(); settle();
    chk("j_back_state", 32'(state), 32'd0);

    // Illegal opcode 0x3F: 2 cycles
    opcode = 6'h3F;
    tick(); settle();
    chk("ill_state", 32'(state), 32'd1);
    chk("ill_illegal", 32'(illegal), 32'd1);
    chk("ill_done", 32'(instr_done), 32'd1);
    chk("ill_regwrite", 32'(RegWrite), 32'd0);
    chk("ill_memwrite", 32'(MemWrite), 32'd0);
    tick(); settle();
    chk("ill_back_state", 32'(state), 32'd0);
    chk("ill_back_illegal", 32'(illegal), 32'd0);

    // ADDI: 0,1,10,11
    opcode = 6'h08;
    tick(); settle();
    chk("addi_decode_illegal", 32'(illegal), 32'd0);
    tick(); settle();
    chk("addi_exec_state", 32'(state), 32'd10);
    chk("addi_exec_aluop", 32'(ALUOp), 32'd3);
    chk("addi_exec_alusrcb", 32'(ALUSrcB), 32'd2);
    tick(); settle();
    chk("addi_wb_state", 32'(state), 32'd11);
    chk("addi_wb_regwrite", 32'(RegWrite), 32'd1);
    chk("addi_wb_regdst", 32'(RegDst), 32'd0);
    chk("addi_wb_memtoreg", 32'(MemtoReg), 32'd0);
    tick(); settle();
    chk("addi_back_state", 32'(state), 32'd0);

    // SB zero-wait: 0,1,2,5 then FETCH
    opcode = 6'h28;
    tick(); tick(); tick(); settle();
    chk("sb_wr_state", 32'(state), 32'd5);
    chk("sb_wr_memwrite", 32'(MemWrite), 32'd1);
    chk("sb_wr_done", 32'(instr_done), 32'd1);
    tick(); settle();
    chk("sb_back_state", 32'(state), 32'd0);

    // SW with rst during the MEMWR wait
    opcode = 6'h2B;
    tick(); tick(); mem_ready = 1'b0; tick(); settle();
    chk("sw_wr_state", 32'(state), 32'd5);
    chk("sw_wr_memwrite", 32'(MemWrite), 32'd1);
    chk("sw_wr_iord", 32'(IorD), 32'd1);
    chk("sw_wr_done", 32'(instr_done), 32'd0);
    tick(); settle();
    chk("sw_wait_state", 32'(state), 32'd5);
    rst = 1'b1; settle();
    chk("sw_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("sw_rst_iord", 32'(IorD), 32'd0);
    tick(); settle();
    chk("sw_after_rst_state", 32'(state), 32'd0);
    chk("sw_after_rst_memread", 32'(MemRead), 32'd0);
    rst = 1'b0; mem_ready = 1'b1; settle();
    chk("sw_resume_state", 32'(state), 32'd0);
    chk("sw_resume_memread", 32'(MemRead), 32'd1);
    chk("sw_resume_iord", 32'(IorD), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
